// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle controller for a 12-bit-operand accumulator CPU.
// Drives a synchronous single-port RAM (one-cycle read latency) and an
// external combinational ALU.
// Every port is registered. The output registers are loaded from the
// next-state values, so each output is valid in the same cycle as the state
// it belongs to.
// Optional feature: define CPU_CTRL_SINGLE_STEP_EN to add the 'step' input
// and a WAIT state that holds the core after every instruction.
module cpu_control_unit #(
  parameter int          ADDR_WIDTH = 28,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_sel,
  input  logic [31:0]           alu_out,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           ac,
  output logic [31:0]           ir,
  output logic                  halted,
  output logic                  instr_done
);

  typedef enum logic [3:0] {
    FETCH        = 4'd0,
    FETCH_WAIT   = 4'd1,
    DECODE       = 4'd2,
    OPERAND      = 4'd3,
    OPERAND_WAIT = 4'd4,
    EXEC         = 4'd5,
    STORE        = 4'd6,
    HALT         = 4'd7
`ifdef CPU_CTRL_SINGLE_STEP_EN
    , WAIT       = 4'd8
`endif
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_HALT  = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b0011;
  localparam logic [3:0] OP_CLEAR = 4'b0100;
  localparam logic [3:0] OP_SKIP  = 4'b0101;
  localparam logic [3:0] OP_JUMP  = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_NOT   = 4'b1010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b100;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(32'd2);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);

  // State that follows the last cycle of an instruction.
`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam state_t AFTER_INSTR = WAIT;
`else
  localparam state_t AFTER_INSTR = FETCH;
`endif

  // Opcodes that go through the ALU, in both register and immediate form.
  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Skip condition selected by IR[11:10]; the accumulator is signed.
  function automatic logic skip_taken(input logic [1:0] cond, input logic [31:0] acc);
    case (cond)
      2'b00:   return acc[31];
      2'b01:   return (acc == 32'd0);
      2'b10:   return (!acc[31]) && (acc != 32'd0);
      default: return 1'b0;
    endcase
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]   pc_r, pc_nxt_s;
  logic [31:0]             ac_r, ac_nxt_s, ir_r, ir_nxt_s, mbr_r, mbr_nxt_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_nxt_s;
  logic                    mem_cs_r, mem_cs_nxt_s, mem_we_r, mem_we_nxt_s;
  logic                    mem_oe_r, mem_oe_nxt_s;
  logic [31:0]             alu_a_r, alu_a_nxt_s, alu_b_r, alu_b_nxt_s;
  logic [2:0]              alu_sel_r, alu_sel_nxt_s;
  logic                    halted_r, halted_nxt_s, instr_done_r, instr_done_nxt_s;

  logic                    imm_s;
  logic [3:0]              opcode_s;
  logic [ADDR_WIDTH-1:0]   oper_addr_s;
  logic [31:0]             imm_val_s;

  assign imm_s       = ir_r[31];
  assign opcode_s    = ir_r[30:27];
  assign oper_addr_s = {{(ADDR_WIDTH-12){1'b0}}, ir_r[11:0]};
  assign imm_val_s   = {20'd0, ir_r[11:0]};

  // Next-state sequencing and architectural register updates.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ac_nxt_s    = ac_r;
    ir_nxt_s    = ir_r;
    mbr_nxt_s   = mbr_r;
    case (state_r)
      FETCH:      state_nxt_s = FETCH_WAIT;
      FETCH_WAIT: begin
        ir_nxt_s    = 32'(mem_rdata);
        state_nxt_s = DECODE;
      end
      DECODE: begin
        pc_nxt_s = pc_r + PC_STEP;
        if (imm_s) begin
          state_nxt_s = EXEC;
        end else begin
          case (opcode_s)
            OP_ADD, OP_LOAD, OP_SUB, OP_AND, OP_OR: state_nxt_s = OPERAND;
            OP_STORE:                               state_nxt_s = STORE;
            OP_HALT:                                state_nxt_s = HALT;
            default:                                state_nxt_s = EXEC;
          endcase
        end
      end
      OPERAND:      state_nxt_s = OPERAND_WAIT;
      OPERAND_WAIT: begin
        mbr_nxt_s   = 32'(mem_rdata);
        state_nxt_s = EXEC;
      end
      EXEC: begin
        state_nxt_s = AFTER_INSTR;
        if (imm_s) begin
          if (is_alu_op(opcode_s)) begin
            ac_nxt_s = alu_out;
          end else begin
            ac_nxt_s = ac_r;
          end
        end else begin
          case (opcode_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: ac_nxt_s = alu_out;
            OP_LOAD:  ac_nxt_s = mbr_r;
            OP_CLEAR: ac_nxt_s = 32'd0;
            OP_NOT:   ac_nxt_s = ~ac_r;
            OP_JUMP:  pc_nxt_s = oper_addr_s;
            OP_SKIP: begin
              if (skip_taken(ir_r[11:10], ac_r)) begin
                pc_nxt_s = pc_r + PC_STEP;
              end else begin
                pc_nxt_s = pc_r;
              end
            end
            default:  ac_nxt_s = ac_r;
          endcase
        end
      end
      STORE: state_nxt_s = AFTER_INSTR;
      HALT:  state_nxt_s = HALT;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      WAIT: begin
        if (step) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = WAIT;
        end
      end
`endif
      default: state_nxt_s = FETCH;
    endcase
  end

  // Output values for the state being entered, registered on the same edge.
  always_comb begin
    mem_addr_nxt_s   = {ADDR_WIDTH{1'b0}};
    mem_wdata_nxt_s  = {DATA_WIDTH{1'b0}};
    mem_cs_nxt_s     = 1'b0;
    mem_we_nxt_s     = 1'b0;
    mem_oe_nxt_s     = 1'b0;
    alu_a_nxt_s      = 32'd0;
    alu_b_nxt_s      = 32'd0;
    alu_sel_nxt_s    = ALU_ADD;
    halted_nxt_s     = 1'b0;
    instr_done_nxt_s = 1'b0;
    case (state_nxt_s)
      FETCH, FETCH_WAIT: begin
        mem_addr_nxt_s = pc_nxt_s;
        mem_cs_nxt_s   = 1'b1;
        mem_oe_nxt_s   = 1'b1;
      end
      OPERAND, OPERAND_WAIT: begin
        mem_addr_nxt_s = oper_addr_s;
        mem_cs_nxt_s   = 1'b1;
        mem_oe_nxt_s   = 1'b1;
      end
      STORE: begin
        mem_addr_nxt_s   = oper_addr_s;
        mem_wdata_nxt_s  = DATA_WIDTH'(ac_nxt_s);
        mem_cs_nxt_s     = 1'b1;
        mem_we_nxt_s     = 1'b1;
        instr_done_nxt_s = 1'b1;
      end
      EXEC: begin
        instr_done_nxt_s = 1'b1;
        if (is_alu_op(opcode_s)) begin
          alu_a_nxt_s   = ac_nxt_s;
          alu_b_nxt_s   = imm_s ? imm_val_s : mbr_nxt_s;
          alu_sel_nxt_s = alu_code(opcode_s);
        end else begin
          alu_sel_nxt_s = ALU_ADD;
        end
      end
      HALT:    halted_nxt_s = 1'b1;
      default: mem_cs_nxt_s = 1'b0;
    endcase
  end

  // State, architectural and output registers; reset presents the first fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FETCH;
      pc_r         <= PC_RESET;
      ac_r         <= 32'd0;
      ir_r         <= 32'd0;
      mbr_r        <= 32'd0;
      mem_addr_r   <= PC_RESET;
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      mem_cs_r     <= 1'b1;
      mem_we_r     <= 1'b0;
      mem_oe_r     <= 1'b1;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_sel_r    <= ALU_ADD;
      halted_r     <= 1'b0;
      instr_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      ac_r         <= ac_nxt_s;
      ir_r         <= ir_nxt_s;
      mbr_r        <= mbr_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      mem_cs_r     <= mem_cs_nxt_s;
      mem_we_r     <= mem_we_nxt_s;
      mem_oe_r     <= mem_oe_nxt_s;
      alu_a_r      <= alu_a_nxt_s;
      alu_b_r      <= alu_b_nxt_s;
      alu_sel_r    <= alu_sel_nxt_s;
      halted_r     <= halted_nxt_s;
      instr_done_r <= instr_done_nxt_s;
    end
  end

  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_cs     = mem_cs_r;
  assign mem_we     = mem_we_r;
  assign mem_oe     = mem_oe_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_sel    = alu_sel_r;
  assign pc         = pc_r;
  assign ac         = ac_r;
  assign ir         = ir_r;
  assign halted     = halted_r;
  assign instr_done = instr_done_r;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed program run through cpu_control_unit with a
// synchronous RAM model and a combinational ALU model.
// Honors CPU_CTRL_SINGLE_STEP_EN when it is defined.
module tb_cpu_control_unit;
  localparam int AW = 28;
  localparam int DW = 32;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam int XW = 1;
`else
  localparam int XW = 0;
`endif

  logic          clk;
  logic          rst_n;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic          step;
`endif
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_cs, mem_we, mem_oe;
  logic [31:0]   alu_a, alu_b, alu_out;
  logic [2:0]    alu_sel;
  logic [AW-1:0] pc;
  logic [31:0]   ac, ir;
  logic          halted, instr_done;

  logic [31:0] img      [0:4095];
  logic [31:0] st_data  [0:4095];
  logic        st_valid [0:4095] = '{default: 1'b0};

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int we_cnt   = 0;
  int cs_cnt   = 0;
  int edges    = 0;

  cpu_control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step       (step),
`endif
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .pc         (pc),
    .ac         (ac),
    .ir         (ir),
    .halted     (halted),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU model.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_a & alu_b;
      3'b001:  alu_out = alu_a + alu_b;
      3'b010:  alu_out = alu_a - alu_b;
      3'b100:  alu_out = alu_a | alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  // Synchronous RAM: writes overlay the bench-loaded image; reads take one cycle.
  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      st_data[mem_addr[11:0]]  <= mem_wdata;
      st_valid[mem_addr[11:0]] <= 1'b1;
    end
    if (mem_cs && mem_oe) begin
      mem_rdata <= st_valid[mem_addr[11:0]] ? st_data[mem_addr[11:0]] : img[mem_addr[11:0]];
    end
  end

  // Activity counters sampled away from the active edge.
  always @(negedge clk) begin
    if (instr_done) done_cnt <= done_cnt + 1;
    if (mem_we)     we_cnt   <= we_cnt + 1;
    if (mem_cs)     cs_cnt   <= cs_cnt + 1;
  end

  // Rising-edge counter.
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where instr_done is seen; returns negedges elapsed.
  task automatic step_instr(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!instr_done && cyc < 40);
    chk({tag, "_done_seen"}, 64'(instr_done), 64'd1);
  endtask

  task automatic next_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int e0, d0, c0;
    for (int i = 0; i < 4096; i++) img[i] = 32'd0;
    img[12'h100] = 32'h1000_011E;  // load 0x11E
    img[12'h102] = 32'h0000_0120;  // add 0x120
    img[12'h104] = 32'h1800_011C;  // store 0x11C
    img[12'h106] = 32'h2000_0000;  // clear
    img[12'h108] = 32'h8000_0005;  // addi 5
    img[12'h10A] = 32'hB800_0001;  // subi 1
    img[12'h10C] = 32'h2000_0000;  // clear
    img[12'h10E] = 32'h2800_0400;  // skip if ac==0
    img[12'h110] = 32'h5000_0000;  // not (must be skipped)
    img[12'h112] = 32'h3000_0100;  // jump 0x100
    img[12'h11E] = 32'd7;
    img[12'h120] = 32'd5;
    rst_n = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", 64'(pc), 64'h100);
    chk("rst_ac", 64'(ac), 64'd0);
    chk("rst_ir", 64'(ir), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_done", 64'(instr_done), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_alu_sel", 64'(alu_sel), 64'd1);
    chk("rst_fetch_addr", 64'(mem_addr), 64'h100);
    rst_n = 1'b1;
    e0 = edges;

    // load: six rising edges from release to ac update
    step_instr("load", cyc);
    chk("load_cycles", 64'(cyc), 64'd5);
    next_edge();
    chk("load_ac", 64'(ac), 64'd7);
    chk("load_pc", 64'(pc), 64'h102);
    chk("load_edges", 64'(edges - e0), 64'd6);
    chk("load_done_pulses", 64'(done_cnt), 64'd1);

    // add
    step_instr("add", cyc);
    chk("add_cycles", 64'(cyc), 64'(6 + XW));
    chk("add_alu_sel", 64'(alu_sel), 64'b001);
    chk("add_alu_a", 64'(alu_a), 64'd7);
    chk("add_alu_b", 64'(alu_b), 64'd5);
    next_edge();
    chk("add_ac", 64'(ac), 64'hC);
    chk("add_ir", 64'(ir), 64'h0000_0120);
    chk("add_alu_sel_idle", 64'(alu_sel), 64'b001);
    chk("add_alu_a_idle", 64'(alu_a), 64'd0);

    // store
    step_instr("store", cyc);
    chk("store_cycles", 64'(cyc), 64'(4 + XW));
    chk("store_we", 64'(mem_we), 64'd1);
    chk("store_oe", 64'(mem_oe), 64'd0);
    chk("store_addr", 64'(mem_addr), 64'h11C);
    chk("store_wdata", 64'(mem_wdata), 64'hC);
    next_edge();
    chk("store_we_cycles", 64'(we_cnt), 64'd1);
    chk("store_mem", 64'(st_data[12'h11C]), 64'hC);

    // clear, addi, subi
    step_instr("clear1", cyc);
    next_edge();
    chk("clear1_ac", 64'(ac), 64'd0);
    step_instr("addi", cyc);
    chk("addi_cycles", 64'(cyc), 64'(4 + XW));
    next_edge();
    chk("addi_ac", 64'(ac), 64'd5);
    step_instr("subi", cyc);
    chk("subi_alu_sel", 64'(alu_sel), 64'b010);
    chk("subi_alu_b", 64'(alu_b), 64'd1);
    next_edge();
    chk("subi_ac", 64'(ac), 64'd4);

    // clear then skip-if-zero: pc advances by 4
    step_instr("clear2", cyc);
    next_edge();
    chk("clear2_pc", 64'(pc), 64'h10E);
    step_instr("skip", cyc);
    chk("skip_cycles", 64'(cyc), 64'(4 + XW));
    next_edge();
    chk("skip_pc", 64'(pc), 64'h112);

    // jump back to 0x100, which now holds halt
    img[12'h100] = 32'h0800_0000;
    step_instr("jump", cyc);
    next_edge();
    chk("jump_pc", 64'(pc), 64'h100);
    chk("jump_ac", 64'(ac), 64'd0);
    chk("jump_done_pulses", 64'(done_cnt), 64'd9);

    // halt holds with memory deselected
    cyc = 0;
    while (!halted && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_reached", 64'(halted), 64'd1);
    chk("halt_cycles", 64'(cyc), 64'(4 + XW));
    #1;
    c0 = cs_cnt;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    #1;
    chk("halt_no_cs", 64'(cs_cnt - c0), 64'd0);
    chk("halt_hold", 64'(halted), 64'd1);
    chk("halt_pc", 64'(pc), 64'h102);
    chk("halt_ir", 64'(ir), 64'h0800_0000);
    chk("halt_ac", 64'(ac), 64'd0);
    chk("halt_no_done", 64'(done_cnt - d0), 64'd0);

    // reset exits HALT, then abort a store mid-cycle
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_pc", 64'(pc), 64'h100);
    img[12'h100] = 32'h1800_013C;  // store 0x13C
    @(negedge clk);
    rst_n = 1'b1;
    chk("first_fetch_addr", 64'(mem_addr), 64'h100);
    chk("first_fetch_cs", 64'(mem_cs), 64'd1);
    cyc = 0;
    while (!mem_we && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_store_reached", 64'(mem_we), 64'd1);
    chk("abort_store_cycles", 64'(cyc), 64'd3);
    chk("abort_store_addr", 64'(mem_addr), 64'h13C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", 64'(mem_we), 64'd0);
    chk("abort_pc", 64'(pc), 64'h100);
    chk("abort_done", 64'(instr_done), 64'd0);
    next_edge();
    chk("abort_no_write", 64'(st_valid[12'h13C]), 64'd0);

`ifdef CPU_CTRL_SINGLE_STEP_EN
    // single step: one instruction, then stall until a step pulse
    img[12'h100] = 32'h1000_011E;
    img[12'h102] = 32'h0000_0120;
    step = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step_instr("ss_load", cyc);
    next_edge();
    d0 = done_cnt;
    c0 = cs_cnt;
    repeat (20) @(negedge clk);
    #1;
    chk("ss_idle_cs", 64'(cs_cnt - c0), 64'd0);
    chk("ss_idle_done", 64'(done_cnt - d0), 64'd0);
    chk("ss_idle_pc", 64'(pc), 64'h102);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("ss_one_instr", 64'(done_cnt - d0), 64'd1);
    chk("ss_ac", 64'(ac), 64'hC);
    chk("ss_pc", 64'(pc), 64'h104);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter RESET_PC, default 'h100, PC value after reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have memory ports mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_rdata (input, DATA_WIDTH), mem_cs, mem_we and mem_oe (outputs, 1 bit each), driving a synchronous single-port RAM whose read data is valid one cycle after the address.
REQ-007 SHALL have ALU ports alu_a and alu_b (outputs, 32 bits), alu_sel (output, 3 bits) and alu_out (input, 32 bits); the ALU is combinational, with codes and=000, add=001, sub=010, or=100.
REQ-008 SHALL have status outputs pc (ADDR_WIDTH), ac (32), ir (32), halted (1) and instr_done (1).

Function
REQ-009 SHALL decode each instruction as: IR[31] = immediate flag, IR[30:27] = opcode, IR[11:0] = operand address or immediate, zero-extended.
REQ-010 SHALL use FSM states FETCH, FETCH_WAIT, DECODE, OPERAND, OPERAND_WAIT, EXEC, STORE and HALT.
REQ-011 SHALL drive mem_addr=pc, mem_cs=1, mem_oe=1 and mem_we=0 in FETCH and FETCH_WAIT, and load ir from mem_rdata at the end of FETCH_WAIT.
REQ-012 SHALL set pc<=pc+2 (modulo 2^ADDR_WIDTH) in DECODE.
REQ-013 SHALL branch from DECODE as follows: register add(0000), load(0010), sub(0111), and(1000) and or(1001) go to OPERAND; store(0011) goes to STORE; halt(0001) goes to HALT; all other opcodes go to EXEC.
REQ-014 SHALL drive mem_addr=IR[11:0], mem_cs=1 and mem_oe=1 in OPERAND and OPERAND_WAIT, and capture MBR from mem_rdata at the end of OPERAND_WAIT.
REQ-015 SHALL, in EXEC for register ALU ops, present alu_a=ac, alu_b=MBR and the matching alu_sel, and load ac<=alu_out at the end of the cycle; load SHALL set ac<=MBR.
REQ-016 SHALL execute immediate ops (IR[31]=1) addi(0000), subi(0111), andi(1000) and ori(1001) in EXEC through the ALU with alu_b=imm; any other immediate opcode SHALL be a no-op.
REQ-017 SHALL, in EXEC: clear(0100) sets ac<=0; not(1010) sets ac<=~ac; jump(0110) sets pc<=IR[11:0]; unlisted register opcodes are no-ops.
REQ-018 SHALL make skip(0101) set pc<=pc+2 when IR[11:10] is 00 and ac<0 (signed), 01 and ac==0, or 10 and ac>0 (signed); 11 never skips.
REQ-019 SHALL drive mem_addr=IR[11:0], mem_wdata=ac, mem_cs=1, mem_we=1 and mem_oe=0 for exactly one cycle in STORE; mem_we SHALL be 0 in every other state.
REQ-020 SHALL take 6 cycles for OPERAND-path instructions and 4 cycles for all others, returning to FETCH afterwards.
REQ-021 SHALL pulse instr_done for exactly one cycle, in the final cycle of each instruction (EXEC or STORE).
REQ-022 SHALL hold HALT indefinitely with halted=1, mem_cs=0, and pc/ac/ir frozen; only rst_n exits HALT.
REQ-023 SHALL keep alu_sel=001 and alu_a/alu_b=0 outside EXEC.

Reset
REQ-024 SHALL, on rst_n=0 and independent of clk, set state=FETCH, pc=RESET_PC, ac=0, ir=0, MBR=0, halted=0, instr_done=0 and mem_we=0.
REQ-025 SHALL abort any in-flight instruction when reset asserts mid-operation, leaving no partial write.
REQ-026 SHALL start the first fetch from RESET_PC on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL add an input port step (1 bit) and a WAIT state entered after each instruction when CPU_CTRL_SINGLE_STEP_EN is defined.
REQ-028 SHALL, with CPU_CTRL_SINGLE_STEP_EN defined, leave WAIT for FETCH on a cycle with step=1, with mem_cs=0 throughout WAIT.
REQ-029 SHALL, without CPU_CTRL_SINGLE_STEP_EN, have no step port and no WAIT state, and run freely.

Verification
REQ-030 SHALL verify load: mem[0x100]=0x1000011E, mem[0x11E]=7, release reset -> after 6 cycles ac=7, pc=0x102, one instr_done pulse.
REQ-031 SHALL verify add: ac=7, instr 0x00000120, mem[0x120]=5 -> alu_sel=001 in EXEC, ac=0xC.
REQ-032 SHALL verify store: ac=0xC, instr 0x1800011C -> exactly one cycle with mem_we=1, mem_addr=0x11C, mem_wdata=0xC.
REQ-033 SHALL verify immediate/skip/jump: ac=5, 0xB8000001 -> ac=4; ac=0, 0x28000400 -> pc advances by 4; 0x30000100 -> pc=0x100.
REQ-034 SHALL verify halt and reset: 0x08000000 -> halted=1 and no mem_cs for 20 cycles; rst_n pulsed low mid-STORE -> mem_we drops immediately, pc=0x100.
REQ-035 SHALL verify single-step with CPU_CTRL_SINGLE_STEP_EN: step held 0 -> no fetch after the first instruction; one step pulse -> exactly one further instruction.
